// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the read-modify-write load/store unit
//
// Purpose : access-size encoding, FSM state encoding and the lane-offset helper
//           used by lsu_rmw and lsu_lane_align.
// Ports   : none (package)

package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_e;

    // Byte offset actually used for the access: the low address bits that
    // would make the access misaligned are dropped.
    function automatic logic [1:0] eff_offset(lsu_size_e size, logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return addr_lo;
            SIZE_HALF: return {addr_lo[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational lane extract/extend and store merge
//
// Purpose : picks the addressed byte/half out of a memory word and extends it,
//           and merges store data into the addressed lanes of a memory word.
// Ports   : word_i       memory word read back
//           size_i       access size
//           off_i        effective byte offset inside the word
//           unsigned_i   1 = zero-extend loads, 0 = sign-extend
//           wdata_i      right-aligned store data
//           load_data_o  extended load result
//           merge_data_o word_i with the addressed lanes replaced by wdata_i

module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  lsu_size_e   size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        case (size_i)
            SIZE_BYTE: load_data_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
            SIZE_HALF: load_data_o = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
            default:   load_data_o = word_i;
        endcase
    end

    always_comb begin
        merge_data_o = word_i;
        case (size_i)
            SIZE_BYTE: merge_data_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            SIZE_HALF: merge_data_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SIZE_WORD: merge_data_o = wdata_i;
            default:   merge_data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store unit doing read-modify-write for sub-word stores
//
// Purpose : accepts one byte/half/word load or store at a time, performs it on a
//           single-ported word memory (read-modify-write for sub-word stores) and
//           returns one response per accepted request.
// Config  : define LSU_RMW_MISALIGN_TRAP_EN to reject misaligned half/word
//           accesses as errors; otherwise misaligned low address bits are ignored.
// Ports   : clk_i, rst_i                      clock, synchronous active-high reset
//           req_valid_i/req_ready_o           request handshake
//           req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i
//           rsp_valid_o/rsp_ready_i           response handshake
//           rsp_rdata_o, rsp_err_o            response payload
//           mem_wr_o, mem_waddr_o, mem_wdata_o, mem_raddr_o, mem_rdata_i  word memory

module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH+1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_e            state_q;
    logic                  we_q;
    lsu_size_e             size_q;
    logic                  unsigned_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  mem_wr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    lsu_size_e             size_d;
    logic [1:0]            off_d;
    logic                  misalign_d;
    logic                  err_d;
    logic                  handshake;
    logic [31:0]           load_data;
    logic [31:0]           merge_data;

    assign size_d = lsu_size_e'(req_size_i);
    assign off_d  = eff_offset(size_d, req_addr_i[1:0]);

`ifdef LSU_RMW_MISALIGN_TRAP_EN
    assign misalign_d = ((size_d == SIZE_HALF) && req_addr_i[0]) ||
                        ((size_d == SIZE_WORD) && (req_addr_i[1:0] != 2'b00));
`else
    assign misalign_d = 1'b0;
`endif

    assign err_d = (size_d == SIZE_ILL) || misalign_d;

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign handshake   = req_valid_i && req_ready_o;

    lsu_lane_align u_lane_align (
        .word_i       (mem_rdata_i),
        .size_i       (size_q),
        .off_i        (off_q),
        .unsigned_i   (unsigned_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
            off_q       <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        we_q       <= req_we_i;
                        size_q     <= size_d;
                        unsigned_q <= req_unsigned_i;
                        off_q      <= off_d;
                        addr_q     <= req_addr_i[ADDR_WIDTH+1:2];
                        wdata_q    <= req_wdata_i;
                        if (err_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (req_we_i && (size_d == SIZE_WORD)) begin
                            // Full-word store needs no read of the old word.
                            state_q     <= WRITE;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= req_wdata_i;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        state_q     <= WRITE;
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= merge_data;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= load_data;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    mem_wr_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset masks the registered outputs in the same cycle so an in-flight
    // write or response is never seen once reset is asserted.
    assign rsp_valid_o = rsp_valid_q && !rst_i;
    assign rsp_err_o   = rsp_err_q && !rst_i;
    assign rsp_rdata_o = rst_i ? '0 : rsp_rdata_q;
    assign mem_wr_o    = mem_wr_q && !rst_i;
    assign mem_waddr_o = rst_i ? '0 : addr_q;
    assign mem_raddr_o = rst_i ? '0 : addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - self-checking bench for lsu_rmw with a transaction-level model

module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [11:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_wr_o;
    logic [9:0]  mem_waddr_o;
    logic [9:0]  mem_raddr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_err = 0;
    logic run_checks = 1'b0;

    always #5 clk = ~clk;

    lsu_rmw #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_wr_o       (mem_wr_o),
        .mem_waddr_o    (mem_waddr_o),
        .mem_raddr_o    (mem_raddr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    // Memory seen by the DUT, plus a poke port used only while idle.
    logic [31:0] dut_mem [1024];
    logic [31:0] ref_mem [1024];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [31:0] poke_val = '0;

    assign mem_rdata_i = dut_mem[mem_raddr_o];

    always @(posedge clk) begin
        if (poke_en) dut_mem[poke_addr] <= poke_val;
        else if (mem_wr_o) dut_mem[mem_waddr_o] <= mem_wdata_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: on each accepted request compute the whole outcome
    // (response, optional memory write, latency) from the access rules.
    logic        m_busy = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;
    int          m_wcyc = 0;
    logic        m_write = 1'b0;
    logic        m_read = 1'b0;
    logic [9:0]  m_widx = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    always @(posedge clk) begin
        if (poke_en) ref_mem[poke_addr] = poke_val;
        if (rst_i) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (req_valid_i) begin : accept
                logic [31:0] word, sh, mask, v;
                int off;
                logic e;
                m_widx = req_addr_i[11:2];
                word = ref_mem[m_widx];
                e = (req_size_i == 2'd3);
`ifdef LSU_RMW_MISALIGN_TRAP_EN
                if (req_size_i == 2'd1 && req_addr_i[0]) e = 1'b1;
                if (req_size_i == 2'd2 && req_addr_i[1:0] != 2'd0) e = 1'b1;
`endif
                if (req_size_i == 2'd0) off = int'(req_addr_i[1:0]);
                else if (req_size_i == 2'd1) off = int'(req_addr_i[1:0]) & 2;
                else off = 0;
                m_write = 1'b0; m_read = 1'b0; m_rdata = '0; m_err = 1'b0;
                m_wcyc = 0;
                if (e) begin
                    m_err = 1'b1; m_lat = 1;
                end else if (!req_we_i) begin
                    m_read = 1'b1; m_lat = 2;
                    sh = word >> (8 * off);
                    if (req_size_i == 2'd0) begin
                        v = sh & 32'hFF;
                        if (!req_unsigned_i && v[7]) v = v | 32'hFFFF_FF00;
                    end else if (req_size_i == 2'd1) begin
                        v = sh & 32'hFFFF;
                        if (!req_unsigned_i && v[15]) v = v | 32'hFFFF_0000;
                    end else v = word;
                    m_rdata = v;
                end else begin
                    m_write = 1'b1;
                    if (req_size_i == 2'd0) mask = 32'hFF << (8 * off);
                    else if (req_size_i == 2'd1) mask = 32'hFFFF << (8 * off);
                    else mask = 32'hFFFF_FFFF;
                    m_wdata = (word & ~mask) | ((req_wdata_i << (8 * off)) & mask);
                    if (req_size_i == 2'd2) begin m_lat = 2; m_wcyc = 1; end
                    else begin m_read = 1'b1; m_lat = 3; m_wcyc = 2; end
                end
                m_busy = 1'b1;
                m_k = 1;
            end
        end else begin
            if (m_write && m_k == m_wcyc) ref_mem[m_widx] = m_wdata;
            if (m_k >= m_lat && rsp_ready_i) m_busy = 1'b0;
            else m_k++;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (run_checks) begin : cmp
            logic exp_wr, exp_v;
            exp_wr = m_busy && m_write && (m_k == m_wcyc) && !rst_i;
            exp_v  = m_busy && (m_k >= m_lat) && !rst_i;
            chk("req_ready", 32'(req_ready_o), 32'(!m_busy && !rst_i));
            chk("mem_wr", 32'(mem_wr_o), 32'(exp_wr));
            if (exp_wr) begin
                chk("mem_waddr", 32'(mem_waddr_o), 32'(m_widx));
                chk("mem_wdata", mem_wdata_o, m_wdata);
            end
            if (m_busy && m_read && m_k == 1 && !rst_i)
                chk("mem_raddr", 32'(mem_raddr_o), 32'(m_widx));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_v));
            if (exp_v) begin
                chk("rsp_rdata", rsp_rdata_o, m_rdata);
                chk("rsp_err", 32'(rsp_err_o), 32'(m_err));
            end
            if (rst_i) begin
                chk("rst_rdata", rsp_rdata_o, 32'h0);
                chk("rst_err", 32'(rsp_err_o), 32'h0);
                chk("rst_addr", 32'({mem_raddr_o, mem_waddr_o}), 32'h0);
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] v);
        @(negedge clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_val = v;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wd, input int stall,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int wr_cnt, output int wr_n, output logic [31:0] wr_data,
                          output logic stall_ok);
        int n;
        logic done;
        lat = -1; rdata = '0; err = 1'b0; wr_cnt = 0; wr_n = 0; wr_data = '0; stall_ok = 1'b1;
        @(negedge clk); #1;
        req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_we_i = 1'($urandom); req_size_i = 2'($urandom);
        req_addr_i = 12'($urandom); req_wdata_i = $urandom;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk); n++;
            if (mem_wr_o) begin wr_cnt++; wr_n = n; wr_data = mem_wdata_o; end
            if (rsp_valid_o) begin done = 1'b1; lat = n; end
            else if (n >= 20) begin
                done = 1'b1;
                n_checks++; n_err++;
                $display("FAIL rsp_timeout: got no response expected one within 20 cycles");
            end
        end
        rdata = rsp_rdata_o; err = rsp_err_o;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (mem_wr_o) wr_cnt++;
            if (!rsp_valid_o || req_ready_o || rsp_rdata_o !== rdata || rsp_err_o !== err)
                stall_ok = 1'b0;
        end
        #1 rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, wr_cnt, wr_n, mism;
        logic [31:0] rdata, wr_data;
        logic err, stall_ok;
        int cnt_wr, cnt_v;

        // Reset state.
        repeat (2) @(posedge clk);
        run_checks = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready_o), 32'h0);
        chk("reset_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset_mem_wr", 32'(mem_wr_o), 32'h0);
        #1 rst_i = 1'b0;

        for (int i = 0; i < 16; i++) poke(10'(i), $urandom);

        // Signed byte load.
        poke(10'h040, 32'h1122_3344);
        do_req(1'b0, 2'd0, 1'b0, 12'h103, 32'h0, 0, lat, rdata, err, wr_cnt, wr_n, wr_data, stall_ok);
        chk("d_lb_rdata", rdata, 32'h0000_0011);
        chk("d_lb_lat", 32'(lat), 32'd2);
        chk("d_lb_nowr", 32'(wr_cnt), 32'd0);

        // Half loads, signed and unsigned.
        poke(10'h040, 32'h80FF_0000);
        do_req(1'b0, 2'd1, 1'b0, 12'h102, 32'h0, 1, lat, rdata, err, wr_cnt, wr_n, wr_data, stall_ok);
        chk("d_lh_rdata", rdata, 32'hFFFF_80FF);
        do_req(1'b0, 2'd1, 1'b1, 12'h102, 32'h0, 0, lat, rdata, err, wr_cnt, wr_n, wr_data, stall_ok);
        chk("d_lhu_rdata", rdata, 32'h0000_80FF);

        // Byte store via read-modify-write.
        poke(10'h080, 32'hAABB_CCDD);
        do_req(1'b1, 2'd0, 1'b0, 12'h201, 32'h0000_0055, 0, lat, rdata, err, wr_cnt, wr_n, wr_data, stall_ok);
        chk("d_sb_wrcnt", 32'(wr_cnt), 32'd1);
        chk("d_sb_wrcyc", 32'(wr_n), 32'd2);
        chk("d_sb_wdata", wr_data, 32'hAABB_55DD);
        chk("d_sb_lat", 32'(lat), 32'd3);

        // Word store with a stalled response.
        do_req(1'b1, 2'd2, 1'b0, 12'h204, 32'hDEAD_BEEF, 3, lat, rdata, err, wr_cnt, wr_n, wr_data, stall_ok);
        chk("d_sw_wrcyc", 32'(wr_n), 32'd1);
        chk("d_sw_wdata", wr_data, 32'hDEAD_BEEF);
        chk("d_sw_lat", 32'(lat), 32'd2);
        chk("d_sw_stall", 32'(stall_ok), 32'd1);

        // Misaligned word load.
        poke(10'h040, 32'h1234_5678);
        do_req(1'b0, 2'd2, 1'b0, 12'h102, 32'h0, 0, lat, rdata, err, wr_cnt, wr_n, wr_data, stall_ok);
`ifdef LSU_RMW_MISALIGN_TRAP_EN
        chk("d_mis_err", 32'(err), 32'd1);
        chk("d_mis_rdata", rdata, 32'h0);
        chk("d_mis_lat", 32'(lat), 32'd1);
`else
        chk("d_mis_err", 32'(err), 32'd0);
        chk("d_mis_rdata", rdata, 32'h1234_5678);
        chk("d_mis_lat", 32'(lat), 32'd2);
`endif

        // Illegal size is always an error.
        do_req(1'b1, 2'd3, 1'b0, 12'h100, 32'h0, 0, lat, rdata, err, wr_cnt, wr_n, wr_data, stall_ok);
        chk("d_ill_err", 32'(err), 32'd1);
        chk("d_ill_lat", 32'(lat), 32'd1);
        chk("d_ill_nowr", 32'(wr_cnt), 32'd0);

        // Reset during the READ cycle of a sub-word store aborts it.
        poke(10'h090, 32'h1234_5678);
        @(negedge clk); #1;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd0; req_addr_i = 12'h241;
        req_wdata_i = 32'hAB;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("d_rst_ready", 32'(req_ready_o), 32'd1);
        cnt_wr = 0; cnt_v = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_wr_o) cnt_wr++;
            if (rsp_valid_o) cnt_v++;
        end
        chk("d_rst_nowr", 32'(cnt_wr), 32'd0);
        chk("d_rst_norsp", 32'(cnt_v), 32'd0);
        chk("d_rst_mem", dut_mem[10'h090], 32'h1234_5678);

        // Randomized traffic on a small address window to exercise RAW reuse.
        for (int t = 0; t < 200; t++) begin : rnd
            int r;
            logic [1:0] sz;
            logic [11:0] a;
            r = int'($urandom_range(0, 15));
            sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            a = {10'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)),
                   lat, rdata, err, wr_cnt, wr_n, wr_data, stall_ok);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (dut_mem[i] !== ref_mem[i]) mism++;
        chk("mem_image", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
LSU_RMW -- requirements
Module: lsu_rmw

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have port clk_i, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, reset; synchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 1 bit, request valid.
REQ-006 SHALL have port req_ready_o, output, 1 bit, request accept.
REQ-007 SHALL have port req_we_i, input, 1 bit, 1 = store, 0 = load.
REQ-008 SHALL have port req_size_i, input, 2 bits, 00 byte / 01 half / 10 word / 11 illegal.
REQ-009 SHALL have port req_unsigned_i, input, 1 bit, load zero-extend when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr_i, input, ADDR_WIDTH+2 bits, byte address.
REQ-011 SHALL have port req_wdata_i, input, 32 bits, store data, right-aligned.
REQ-012 SHALL have port rsp_valid_o, output, 1 bit, response valid.
REQ-013 SHALL have port rsp_ready_i, input, 1 bit, response accept.
REQ-014 SHALL have port rsp_rdata_o, output, 32 bits, extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err_o, output, 1 bit, request rejected without memory access.
REQ-016 SHALL have ports mem_wr_o (output, 1), mem_waddr_o / mem_raddr_o (output, ADDR_WIDTH), mem_wdata_o (output, 32), word memory write/read port.
REQ-017 SHALL have port mem_rdata_i, input, 32 bits; combinational read of mem_raddr_o, valid only while mem_wr_o=0.

Function
REQ-018 SHALL use FSM states IDLE, READ, WRITE, RESP.
REQ-019 SHALL drive req_ready_o=1 only in IDLE with rst_i=0; a handshake is req_valid_i & req_ready_o, and the request fields are captured on it.
REQ-020 SHALL transition from IDLE on handshake: error -> RESP; load or sub-word store -> READ; word store -> WRITE.
REQ-021 SHALL, in READ, keep mem_wr_o=0 and mem_raddr_o=addr[ADDR_WIDTH+1:2], and capture mem_rdata_i; a load then goes to RESP, a sub-word store goes to WRITE.
REQ-022 SHALL, in WRITE, assert mem_wr_o=1 for exactly one cycle, with mem_waddr_o = word address and mem_wdata_o = captured word with the selected byte/half lanes replaced (word store: req_wdata_i unchanged), then go to RESP.
REQ-023 SHALL, for loads, select the lane by addr[1:0] and sign- or zero-extend it per req_unsigned_i.
REQ-024 SHALL hold rsp_valid_o=1 in RESP until rsp_ready_i=1, then return to IDLE; response fields stay stable while stalled.
REQ-025 SHALL give latency from the handshake cycle T to rsp_valid_o: error T+1, load T+2, word store T+2, sub-word store T+3.
REQ-026 SHALL treat req_size_i=11 as an error, always.
REQ-027 SHALL accept no new request in the cycle a response is accepted; IDLE follows.

Reset
REQ-028 SHALL, while rst_i=1, force next state IDLE, with rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_wr_o=0, req_ready_o=0, addresses 0.
REQ-029 SHALL abort any in-flight request on reset, with no memory write in the reset cycle or after it, and no response for the aborted request.

Configuration
REQ-030 SHALL, with macro LSU_RMW_MISALIGN_TRAP_EN defined, treat half at addr[0]=1 and word at addr[1:0]!=0 as errors.
REQ-031 SHALL, without LSU_RMW_MISALIGN_TRAP_EN, ignore the misaligned low address bits (force them to 0) and perform the access normally.

Structure
REQ-032 SHALL place the size encoding enum and the FSM state enum in shared package lsu_pkg.
REQ-033 SHALL implement lane extract/extend and store merge in combinational sub-module lsu_lane_align.

Verification
REQ-034 SHALL verify: word 0x100 = 0x11223344; load byte signed addr 0x103 -> rsp_rdata_o=0x00000011 at T+2, mem_wr_o never 1.
REQ-035 SHALL verify: word 0x100 = 0x80FF0000; load half signed addr 0x102 -> 0xFFFF80FF; load half unsigned -> 0x000080FF.
REQ-036 SHALL verify: word 0x200 = 0xAABBCCDD; store byte 0x55 at addr 0x201 -> one mem_wr_o pulse at T+2, mem_wdata_o=0xAABB55DD, rsp_valid_o at T+3.
REQ-037 SHALL verify: store word 0xDEADBEEF at addr 0x204 -> mem_wr_o at T+1, rsp_valid_o at T+2; rsp_ready_i held low 3 cycles -> rsp_valid_o held and req_ready_o=0 throughout.
REQ-038 SHALL verify: with LSU_RMW_MISALIGN_TRAP_EN, word load at addr 0x102 -> rsp_err_o=1, rsp_rdata_o=0 at T+1, no memory access; without the macro -> the word at 0x100 is returned.
REQ-039 SHALL verify: rst_i asserted in the READ cycle of a sub-word store -> no mem_wr_o pulse, no response, req_ready_o=1 the cycle after rst_i falls.
